// File: rtl/issue_queue.sv
// Compacting out-of-order issue queue: age-ordered slots, tag wakeup from two
// writeback ports, oldest-ready selection and color-aware branch squash.
module issue_queue #(
  parameter int DEPTH  = 8,
  parameter int PR_W   = 6,
  parameter int AL_W   = 5,
  parameter int ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [ADDR_W-1:0]       in_pc,
  input  logic [PR_W-1:0]         in_phys_rs,
  input  logic [PR_W-1:0]         in_phys_rt,
  input  logic [PR_W-1:0]         in_phys_rw,
  input  logic                    in_uses_rs,
  input  logic                    in_uses_rt,
  input  logic                    in_uses_rw,
  input  logic                    in_rs_ready,
  input  logic                    in_rt_ready,
  input  logic                    in_is_load,
  input  logic                    in_is_store,
  input  logic [AL_W-1:0]         in_al_id,
  input  logic                    in_color,
  input  logic                    wb_alu_valid,
  input  logic                    wb_load_valid,
  input  logic [PR_W-1:0]         wb_alu_tag,
  input  logic [PR_W-1:0]         wb_load_tag,
  input  logic                    flush_valid,
  input  logic [AL_W-1:0]         flush_al_id,
  input  logic                    flush_color,
  input  logic                    issue_stall,
  output logic                    issue_valid,
  output logic [ADDR_W-1:0]       issue_pc,
  output logic [PR_W-1:0]         issue_phys_rs,
  output logic [PR_W-1:0]         issue_phys_rt,
  output logic [PR_W-1:0]         issue_phys_rw,
  output logic                    issue_uses_rw,
  output logic                    issue_is_load,
  output logic                    issue_is_store,
  output logic [AL_W-1:0]         issue_al_id,
  output logic                    issue_color,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [PR_W-1:0]   phys_rs;
    logic [PR_W-1:0]   phys_rt;
    logic [PR_W-1:0]   phys_rw;
    logic              uses_rs;
    logic              uses_rt;
    logic              uses_rw;
    logic              rs_ready;
    logic              rt_ready;
    logic              is_load;
    logic              is_store;
    logic [AL_W-1:0]   al_id;
    logic              color;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  entry_t           woke  [DEPTH];
  logic [DEPTH-1:0] keep;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [CW-1:0]    wr;
  logic             sel_found;
  logic [IW-1:0]    sel_idx;
  entry_t           sel_ent;
  entry_t           new_ent;
  logic             accept;
  logic             fire;

  function automatic logic wb_hit(input logic [PR_W-1:0] tag);
    return (wb_alu_valid && (tag == wb_alu_tag)) || (wb_load_valid && (tag == wb_load_tag));
  endfunction

  // Same color: larger id was allocated later. Different color: the list wrapped.
  function automatic logic is_younger(input logic [AL_W-1:0] al, input logic col);
    return (col == flush_color) ? (al > flush_al_id) : (al < flush_al_id);
  endfunction

  assign full        = (count_q == DEPTH_C);
  assign count       = count_q;
  assign issue_valid = sel_found && !flush_valid;
  assign fire        = issue_valid && !issue_stall;
  assign accept      = in_valid && !full && !flush_valid;

  // Oldest ready wins: scanning downward leaves the lowest index selected.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((CW'(i) < count_q) && ent_q[i].rs_ready && ent_q[i].rt_ready) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  assign sel_ent        = issue_valid ? ent_q[sel_idx] : '0;
  assign issue_pc       = sel_ent.pc;
  assign issue_phys_rs  = sel_ent.phys_rs;
  assign issue_phys_rt  = sel_ent.phys_rt;
  assign issue_phys_rw  = sel_ent.phys_rw;
  assign issue_uses_rw  = sel_ent.uses_rw;
  assign issue_is_load  = sel_ent.is_load;
  assign issue_is_store = sel_ent.is_store;
  assign issue_al_id    = sel_ent.al_id;
  assign issue_color    = sel_ent.color;

  always_comb begin
    new_ent          = '0;
    new_ent.pc       = in_pc;
    new_ent.phys_rs  = in_phys_rs;
    new_ent.phys_rt  = in_phys_rt;
    new_ent.phys_rw  = in_phys_rw;
    new_ent.uses_rs  = in_uses_rs;
    new_ent.uses_rt  = in_uses_rt;
    new_ent.uses_rw  = in_uses_rw;
    new_ent.rs_ready = !in_uses_rs || in_rs_ready || wb_hit(in_phys_rs);
    new_ent.rt_ready = !in_uses_rt || in_rt_ready || wb_hit(in_phys_rt);
    new_ent.is_load  = in_is_load;
    new_ent.is_store = in_is_store;
    new_ent.al_id    = in_al_id;
    new_ent.color    = in_color;
  end

  // Wakeup applies to every resident entry, including flush survivors.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i]          = ent_q[i];
      woke[i].rs_ready = ent_q[i].rs_ready || wb_hit(ent_q[i].phys_rs);
      woke[i].rt_ready = ent_q[i].rt_ready || wb_hit(ent_q[i].phys_rt);
      keep[i]          = (CW'(i) < count_q) &&
                         (flush_valid ? !is_younger(ent_q[i].al_id, ent_q[i].color)
                                      : !(fire && (IW'(i) == sel_idx)));
    end
  end

  // Order-preserving compaction of kept entries, then append the dispatch.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
    wr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (keep[i]) begin
        ent_d[wr[IW-1:0]] = woke[i];
        wr = wr + CW'(1);
      end
    end
    if (accept) begin
      ent_d[wr[IW-1:0]] = new_ent;
      wr = wr + CW'(1);
    end
    count_d = wr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

endmodule
